// File: rtl/marvin_servo_pkg.sv
// +-----------------------------------------------------------------------------+
// | Package : marvin_servo_pkg                                                   |
// | Shared servo types and timing helpers (ramp FSM encoding, cycle derivation).|
// | Revision: 1.0 - initial release                                              |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package marvin_servo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    // Number of clock periods in an interval; also used by pwmgen so both agree on frame length.
    function automatic int cycles(input time t, input time t_clk);
        return int'(t / t_clk);
    endfunction

endpackage

`default_nettype wire

// File: rtl/servo_frame_tick.sv
// +-----------------------------------------------------------------------------+
// | Module  : servo_frame_tick                                                   |
// | Frame counter 0..DUTY_-1 with a strobe in the last cycle of each frame.     |
// | Revision: 1.0 - initial release                                              |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module servo_frame_tick #(
    parameter int DUTY_ = 10
) (
    input  logic clk,
    input  logic rst_,
    input  logic ena,
    output logic frame
);

    localparam int            CW   = (DUTY_ > 1) ? $clog2(DUTY_) : 1;
    localparam logic [CW-1:0] LAST = CW'(DUTY_ - 1);

    logic [CW-1:0] fcnt_q;
    logic [CW-1:0] fcnt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        if (!ena || (fcnt_q == LAST)) begin
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame = ena && (fcnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/servo_ramp.sv
// +-----------------------------------------------------------------------------+
// | Module  : servo_ramp                                                         |
// | Slew-rate limiter: moves pos toward an accepted target by at most STEP_     |
// | counts per PWM frame; updates land only on frame boundaries.                |
// | Option  : SERVO_RAMP_LIMIT_EN clamps accepted targets to [LO_, HI_].        |
// | Revision: 1.0 - initial release                                              |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module servo_ramp
    import marvin_servo_pkg::*;
#(
    parameter time CLK_  = 20ns,
    parameter time DUTY  = 20ms,
    parameter int  POS_  = 8,
    parameter int  STEP_ = 4,
    parameter int  INIT  = 2**(POS_-1),
    parameter int  LO_   = 0,
    parameter int  HI_   = 2**POS_-1
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            ena,
    input  logic [POS_-1:0] tgt,
    input  logic            tgt_vld,
    output logic            tgt_rdy,
    output logic [POS_-1:0] pos,
    output logic            frame,
    output logic            busy
);

    localparam int              DUTY_  = cycles(DUTY, CLK_);
    localparam int              POS1   = POS_ + 1;
    localparam logic [POS_-1:0] STEP_P = POS_'(STEP_);
    localparam logic [POS1-1:0] STEP_W = POS1'(STEP_);
    localparam logic [POS_-1:0] INIT_P = POS_'(INIT);
    localparam logic [POS_-1:0] LO_P   = POS_'(LO_);
    localparam logic [POS_-1:0] HI_P   = POS_'(HI_);

`ifdef SERVO_RAMP_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    ramp_state_t        state_q;
    ramp_state_t        state_d;
    logic [POS_-1:0]    pos_q;
    logic [POS_-1:0]    pos_d;
    logic [POS_-1:0]    target_q;
    logic [POS_-1:0]    target_d;
    logic               rdy_q;

    logic               accept;
    logic [POS_-1:0]    tgt_lim;
    logic signed [POS1-1:0] diff;
    logic [POS1-1:0]    mag;

    servo_frame_tick #(
        .DUTY_ (DUTY_)
    ) u_tick (
        .clk   (clk),
        .rst_  (rst_),
        .ena   (ena),
        .frame (frame)
    );

    // rdy_q only marks "out of reset"; ena gates the handshake combinationally.
    assign tgt_rdy = ena && rdy_q;
    assign accept  = tgt_vld && tgt_rdy;

    always_comb begin
        tgt_lim = tgt;
        if (LIMIT_EN) begin
            if (tgt < LO_P) begin
                tgt_lim = LO_P;
            end else if (tgt > HI_P) begin
                tgt_lim = HI_P;
            end
        end
    end

    // Unsigned operands extended by one bit so the difference never wraps.
    always_comb begin
        diff = $signed({1'b0, target_q}) - $signed({1'b0, pos_q});
        mag  = diff[POS1-1] ? $unsigned(-diff) : $unsigned(diff);
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        target_d = target_q;

        if (frame && (state_q == RAMP)) begin
            if (mag <= STEP_W) begin
                pos_d   = target_q;
                state_d = IDLE;
            end else if (diff[POS1-1]) begin
                pos_d = pos_q - STEP_P;
            end else begin
                pos_d = pos_q + STEP_P;
            end
        end

        // A coincident step already used the old target; the new one is judged against the stepped pos.
        if (accept) begin
            target_d = tgt_lim;
            state_d  = (tgt_lim != pos_d) ? RAMP : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= IDLE;
            pos_q    <= INIT_P;
            target_q <= INIT_P;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            rdy_q    <= 1'b1;
        end
    end

    assign pos  = pos_q;
    assign busy = (state_q == RAMP);

endmodule

`default_nettype wire
